// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and entry type for the register hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [1:0] LOAD_READY_CNT = 2'd1;
  localparam logic [1:0] ALU_READY_CNT  = 2'd0;
  localparam logic [1:0] LIFE_CNT       = 2'd3;

  typedef struct packed {
    logic [1:0] ready_cnt;
    logic [1:0] life_cnt;
  } entry_t;

  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One scoreboard entry: ready/life counter pair with load, flush-clear and
// saturating decrement.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   load_i,
  input  logic   mem_read_i,
  input  logic   flush_i,
  output entry_t entry_o
);

  entry_t state;

  // Load wins over flush and decrement; a flush only squashes the writer
  // that is currently in EX, which is the one whose life is still full.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= '0;
    end else if (load_i) begin
      state.ready_cnt <= mem_read_i ? LOAD_READY_CNT : ALU_READY_CNT;
      state.life_cnt  <= LIFE_CNT;
    end else if (flush_i && (state.life_cnt == LIFE_CNT)) begin
      state <= '0;
    end else begin
      state.ready_cnt <= dec_sat(state.ready_cnt);
      state.life_cnt  <= dec_sat(state.life_cnt);
    end
  end

  assign entry_o = state;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight writers to x1..x31 and raises
// a load-use stall for the instruction in ID.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ID_valid_i,
  input  logic [REG_ADDR_W-1:0] ID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] ID_RS2addr_i,
  input  logic                  ID_RS1use_i,
  input  logic                  ID_RS2use_i,
  input  logic [REG_ADDR_W-1:0] ID_RDaddr_i,
  input  logic                  ID_RegWrite_i,
  input  logic                  ID_MemRead_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [NUM_REGS-1:0]   busy_o
);

  entry_t entries [NUM_REGS];
  logic   issue;
  logic   rs1_hit;
  logic   rs2_hit;

  // x0 is never tracked; its slot is a constant empty entry.
  assign entries[0] = '0;

  // Handshake: ID_valid_i is the ID-stage valid and !stall_o is its ready;
  // an instruction leaves ID only in a cycle with valid && !stall_o, and a
  // flush in the same cycle squashes it instead.
  always_comb begin
    rs1_hit = ID_RS1use_i && (ID_RS1addr_i != '0) &&
              (entries[ID_RS1addr_i].ready_cnt != 2'd0);
    rs2_hit = ID_RS2use_i && (ID_RS2addr_i != '0) &&
              (entries[ID_RS2addr_i].ready_cnt != 2'd0);
    stall_o = ID_valid_i && !flush_i && (rs1_hit || rs2_hit);
    issue   = ID_valid_i && !stall_o && !flush_i && ID_RegWrite_i &&
              (ID_RDaddr_i != '0);
  end

  for (genvar n = 1; n < NUM_REGS; n++) begin : g_entry
    scoreboard_entry u_entry (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (issue && (ID_RDaddr_i == REG_ADDR_W'(n))),
      .mem_read_i (ID_MemRead_i),
      .flush_i    (flush_i),
      .entry_o    (entries[n])
    );
  end

  always_comb begin
    busy_o = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      busy_o[n] = (entries[n].life_cnt != 2'd0);
    end
  end

endmodule
